cu_seq_ctrl: RTL and testbench

Sequencer for the 3x3 cu_engine PE array.
- Per job: loads one 72-bit filter from the weight buffer, then streams num_beats 24-bit pixel beats from the input buffer into the engine.
- Generates the row-staggered fill/drain pe_en_ctrl pattern.
- Flags the cycles on which pe_out is valid, then signals done.

---
 rtl/cu_pkg.sv | 20 ++
 rtl/cu_en_mask_gen.sv | 29 ++
 rtl/cu_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cu_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared sizing constants and sequencer state encoding for the cu_engine
// control path.
package cu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PE_ROWS  = 3;
  localparam int unsigned PE_COLS  = 3;
  localparam int unsigned FILTER_W = PE_ROWS * PE_COLS * DATA_W;
  localparam int unsigned PIX_W    = PE_COLS * DATA_W;
  localparam int unsigned EN_W     = PE_ROWS * PE_COLS;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StFlush
  } seq_state_e;

endpackage

// File: rtl/cu_en_mask_gen.sv
// Row-staggered PE enable mask: row r is live on step k when the beat that
// reaches it (k - r) is one of the job's num_beats beats.
module cu_en_mask_gen
  import cu_pkg::*;
#(
  parameter int unsigned BEATS_W = 16
) (
  input  logic [BEATS_W+1:0] k_i,
  input  logic [BEATS_W-1:0] num_beats_i,
  output logic [EN_W-1:0]    mask_o
);

  localparam int unsigned KW = BEATS_W + 2;

  logic [KW-1:0] nb_ext;

  assign nb_ext = KW'(num_beats_i);

  always_comb begin
    mask_o = '0;
    for (int unsigned r = 0; r < PE_ROWS; r++) begin
      // The k >= r guard keeps k - r from wrapping.
      if ((k_i >= KW'(r)) && ((k_i - KW'(r)) < nb_ext)) begin
        mask_o[r*PE_COLS +: PE_COLS] = '1;
      end
    end
  end

endmodule

// File: rtl/cu_seq_ctrl.sv
// Job sequencer for the 3x3 cu_engine: loads a filter, streams pixel beats,
// drains the array and reports pe_out validity and job completion.
module cu_seq_ctrl
  import cu_pkg::*;
#(
  parameter int unsigned BEATS_W = 16,
  parameter int unsigned PE_LAT  = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [BEATS_W-1:0]  num_beats,
  input  logic                w_valid,
  input  logic [FILTER_W-1:0] w_data,
  output logic                w_ready,
  input  logic                d_valid,
  input  logic [PIX_W-1:0]    d_data,
  output logic                d_ready,
  output logic [FILTER_W-1:0] filter,
  output logic [PIX_W-1:0]    data_in,
  output logic [EN_W-1:0]     pe_en_ctrl,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned KW      = BEATS_W + 2;
  localparam int unsigned FLUSH_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  seq_state_e          state_q;
  logic [BEATS_W-1:0]  nb_q;
  logic [KW-1:0]       k_q;
  logic [KW-1:0]       nb_ext;
  logic [FLUSH_W-1:0]  flush_q;
  logic [FILTER_W-1:0] filter_q;
  logic [PIX_W-1:0]    data_q;
  logic [EN_W-1:0]     en_q;
  logic [EN_W-1:0]     mask;
  logic                w_ready_q;
  logic                d_ready_q;
  logic                busy_q;
  logic                done_q;
  logic [PE_LAT-1:0]   ov_q;

  assign nb_ext = KW'(nb_q);

  cu_en_mask_gen #(
    .BEATS_W (BEATS_W)
  ) u_mask (
    .k_i         (k_q),
    .num_beats_i (nb_q),
    .mask_o      (mask)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= StIdle;
      nb_q      <= '0;
      k_q       <= '0;
      flush_q   <= '0;
      filter_q  <= '0;
      data_q    <= '0;
      en_q      <= '0;
      w_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      en_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            nb_q    <= num_beats;
            k_q     <= '0;
            flush_q <= '0;
            busy_q  <= 1'b1;
            if (num_beats == '0) begin
              state_q <= StFlush;
            end else begin
              state_q   <= StLoadW;
              w_ready_q <= 1'b1;
            end
          end
        end

        StLoadW: begin
          if (w_valid && w_ready_q) begin
            filter_q  <= w_data;
            w_ready_q <= 1'b0;
            d_ready_q <= 1'b1;
            k_q       <= '0;
            state_q   <= StStream;
          end
        end

        StStream: begin
          // Without a handshake the cycle is a bubble: enables drop, data holds.
          if (d_valid && d_ready_q) begin
            data_q <= d_data;
            en_q   <= mask;
            k_q    <= k_q + 1'b1;
            if (k_q + 1'b1 == nb_ext) begin
              d_ready_q <= 1'b0;
              flush_q   <= '0;
              state_q   <= (PE_ROWS > 1) ? StDrain : StFlush;
            end
          end
        end

        StDrain: begin
          data_q <= '0;
          en_q   <= mask;
          k_q    <= k_q + 1'b1;
          if (k_q == nb_ext + KW'(PE_ROWS - 2)) begin
            flush_q <= '0;
            state_q <= StFlush;
          end
        end

        StFlush: begin
          // Hold until the last step's pe_out has emerged from the engine.
          if (flush_q == FLUSH_W'(PE_LAT - 1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // out_valid tracks issued steps through the engine's pipeline latency.
  always_ff @(posedge clk) begin
    if (nrst) begin
      ov_q <= '0;
    end else begin
      ov_q[0] <= |en_q;
      for (int unsigned i = 1; i < PE_LAT; i++) begin
        ov_q[i] <= ov_q[i-1];
      end
    end
  end

  assign w_ready    = w_ready_q;
  assign d_ready    = d_ready_q;
  assign filter     = filter_q;
  assign data_in    = data_q;
  assign pe_en_ctrl = en_q;
  assign out_valid  = ov_q[PE_LAT-1];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cu_seq_ctrl.sv
// Scoreboard bench for cu_seq_ctrl: directed jobs push expected steps and
// completions; a negedge monitor pops and compares as the DUT produces them.
module tb_cu_seq_ctrl;

  localparam int PE_LAT = 1;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [15:0] num_beats;
  logic        w_valid;
  logic [71:0] w_data;
  logic        w_ready;
  logic        d_valid;
  logic [23:0] d_data;
  logic        d_ready;
  logic [71:0] filter;
  logic [23:0] data_in;
  logic [8:0]  pe_en_ctrl;
  logic        out_valid;
  logic        busy;
  logic        done;

  cu_seq_ctrl #(
    .BEATS_W (16),
    .PE_LAT  (PE_LAT)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .num_beats  (num_beats),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .w_ready    (w_ready),
    .d_valid    (d_valid),
    .d_data     (d_data),
    .d_ready    (d_ready),
    .filter     (filter),
    .data_in    (data_in),
    .pe_en_ctrl (pe_en_ctrl),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  en;
    logic [23:0] data;
    int          gap;
  } step_t;

  typedef struct {
    int ov;
    bit zero_job;
  } done_t;

  step_t sq[$];
  done_t dq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_step(input logic [8:0] en, input logic [23:0] data, input int gap);
    step_t s;
    s.en = en;
    s.data = data;
    s.gap = gap;
    sq.push_back(s);
  endtask

  task automatic push_done(input int ov, input bit zero_job);
    done_t d;
    d.ov = ov;
    d.zero_job = zero_job;
    dq.push_back(d);
  endtask

  // Monitor
  int   cyc = 0;
  int   gap = -1;
  int   ov_cnt = 0;
  int   rise_cyc = 0;
  int   last_step = 0;
  logic busy_prev = 1'b0;
  logic exp_ov = 1'b0;

  always @(negedge clk) begin
    step_t s;
    done_t d;
    cyc++;
    chk("out_valid", 72'(out_valid), 72'(exp_ov));
    exp_ov = (pe_en_ctrl != 9'h0) && !nrst;
    if (busy && !busy_prev) begin
      gap = -1;
      ov_cnt = 0;
      rise_cyc = cyc;
    end
    if (out_valid) ov_cnt++;
    if (pe_en_ctrl != 9'h0) begin
      if (sq.size() == 0) begin
        chk("step_extra", 72'(pe_en_ctrl), 72'h0);
      end else begin
        s = sq.pop_front();
        chk("pe_en_ctrl", 72'(pe_en_ctrl), 72'(s.en));
        chk("data_in", 72'(data_in), 72'(s.data));
        if (s.gap >= 0) chk("bubble_gap", 72'(gap), 72'(s.gap));
      end
      gap = 0;
      last_step = cyc;
    end else if (gap >= 0) begin
      gap++;
    end
    if (done) begin
      if (dq.size() == 0) begin
        chk("done_extra", 72'(done), 72'h0);
      end else begin
        d = dq.pop_front();
        chk("busy_at_done", 72'(busy), 72'h0);
        chk("out_valid_count", 72'(ov_cnt), 72'(d.ov));
        if (d.zero_job) chk("done_lat_zero", 72'(cyc - rise_cyc), 72'(PE_LAT));
        else            chk("done_lat", 72'(cyc - last_step), 72'(PE_LAT));
      end
    end
    busy_prev = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 72'(busy), 72'h0);
    chk({tag, "_pe_en"}, 72'(pe_en_ctrl), 72'h0);
    chk({tag, "_data_in"}, 72'(data_in), 72'h0);
    chk({tag, "_filter"}, filter, 72'h0);
    chk({tag, "_out_valid"}, 72'(out_valid), 72'h0);
    chk({tag, "_done"}, 72'(done), 72'h0);
    chk({tag, "_w_ready"}, 72'(w_ready), 72'h0);
    chk({tag, "_d_ready"}, 72'(d_ready), 72'h0);
  endtask

  task automatic run_job(input int nb, input logic [71:0] filt, input logic [23:0] beats[8],
                         input logic [15:0] vpat, input int stall, input bit mid_start,
                         input bit rst_drain);
    logic [71:0] old_f;
    int idx;
    int vi;
    int guard;
    start = 1'b1;
    num_beats = 16'(nb);
    tick();
    start = 1'b0;
    if (nb != 0) begin
      old_f = filter;
      for (int i = 0; i < stall; i++) begin
        w_valid = 1'b0;
        chk("stall_d_ready", 72'(d_ready), 72'h0);
        chk("stall_pe_en", 72'(pe_en_ctrl), 72'h0);
        chk("stall_filter", filter, old_f);
        tick();
      end
      w_valid = 1'b1;
      w_data = filt;
      chk("w_ready", 72'(w_ready), 72'h1);
      tick();
      w_valid = 1'b0;
      chk("filter_load", filter, filt);
      idx = 0;
      vi = 0;
      guard = 0;
      while (idx < nb && guard < 200) begin
        d_valid = (vi < 16) ? vpat[vi] : 1'b1;
        d_data = beats[idx];
        start = mid_start && (vi == 1);
        num_beats = (mid_start && (vi == 1)) ? 16'd9 : 16'(nb);
        if (d_valid && d_ready) idx++;
        vi++;
        guard++;
        tick();
      end
      d_valid = 1'b0;
      start = 1'b0;
      if (guard >= 200) chk("stream_timeout", 72'(idx), 72'(nb));
      if (rst_drain) begin
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        check_idle_zero("mid_rst");
        for (int i = 0; i < 4; i++) tick();
        return;
      end
    end
    guard = 0;
    while (busy && guard < 50) begin
      tick();
      guard++;
    end
    chk("job_complete", 72'(busy), 72'h0);
    tick();
  endtask

  logic [23:0] bt[8];

  initial begin
    nrst = 1'b1;
    start = 1'b0;
    num_beats = '0;
    w_valid = 1'b0;
    w_data = '0;
    d_valid = 1'b0;
    d_data = '0;
    for (int i = 0; i < 8; i++) bt[i] = '0;
    repeat (3) tick();
    nrst = 1'b0;
    check_idle_zero("reset");

    // 1: basic four-beat job
    bt[0] = 24'h020100; bt[1] = 24'h050403; bt[2] = 24'h080706; bt[3] = 24'h0b0a09;
    push_step(9'h007, 24'h020100, -1);
    push_step(9'h03F, 24'h050403, 0);
    push_step(9'h1FF, 24'h080706, 0);
    push_step(9'h1FF, 24'h0b0a09, 0);
    push_step(9'h1F8, 24'h000000, 0);
    push_step(9'h1C0, 24'h000000, 0);
    push_done(6, 1'b0);
    run_job(4, 72'h010000000100000001, bt, 16'hFFFF, 0, 1'b0, 1'b0);
    chk("filter_hold", filter, 72'h010000000100000001);

    // 2: single beat
    bt[0] = 24'hABCDEF;
    push_step(9'h007, 24'hABCDEF, -1);
    push_step(9'h038, 24'h000000, 0);
    push_step(9'h1C0, 24'h000000, 0);
    push_done(3, 1'b0);
    run_job(1, 72'h112233445566778899, bt, 16'hFFFF, 0, 1'b0, 1'b0);

    // 3: bubbles on the pixel stream
    bt[0] = 24'h111111; bt[1] = 24'h222222; bt[2] = 24'h333333;
    push_step(9'h007, 24'h111111, -1);
    push_step(9'h03F, 24'h222222, 1);
    push_step(9'h1FF, 24'h333333, 1);
    push_step(9'h1F8, 24'h000000, 0);
    push_step(9'h1C0, 24'h000000, 0);
    push_done(5, 1'b0);
    run_job(3, 72'h0102030405060708AA, bt, 16'b1111_1111_1111_0101, 0, 1'b0, 1'b0);

    // 4: weight stall with pixels already offered
    bt[0] = 24'hC0FFEE; bt[1] = 24'hBEEF01;
    push_step(9'h007, 24'hC0FFEE, -1);
    push_step(9'h03F, 24'hBEEF01, 0);
    push_step(9'h1F8, 24'h000000, 0);
    push_step(9'h1C0, 24'h000000, 0);
    push_done(4, 1'b0);
    d_valid = 1'b1;
    run_job(2, 72'hFEDCBA987654321000, bt, 16'hFFFF, 5, 1'b0, 1'b0);

    // 5a: zero-beat job
    push_done(0, 1'b1);
    run_job(0, 72'h0, bt, 16'hFFFF, 0, 1'b0, 1'b0);

    // 5b: start pulsed mid-stream is ignored
    bt[0] = 24'h0A0B0C; bt[1] = 24'h0D0E0F; bt[2] = 24'h101112;
    push_step(9'h007, 24'h0A0B0C, -1);
    push_step(9'h03F, 24'h0D0E0F, 0);
    push_step(9'h1FF, 24'h101112, 0);
    push_step(9'h1F8, 24'h000000, 0);
    push_step(9'h1C0, 24'h000000, 0);
    push_done(5, 1'b0);
    run_job(3, 72'h5A5A5A5A5A5A5A5A5A, bt, 16'hFFFF, 0, 1'b1, 1'b0);
    repeat (5) tick();
    chk("no_requeue_busy", 72'(busy), 72'h0);

    // 6: reset during DRAIN aborts silently, then a fresh job runs
    bt[0] = 24'h000001; bt[1] = 24'h000002; bt[2] = 24'h000003; bt[3] = 24'h000004;
    push_step(9'h007, 24'h000001, -1);
    push_step(9'h03F, 24'h000002, 0);
    push_step(9'h1FF, 24'h000003, 0);
    push_step(9'h1FF, 24'h000004, 0);
    run_job(4, 72'h777777777777777777, bt, 16'hFFFF, 0, 1'b0, 1'b1);
    bt[0] = 24'h123456; bt[1] = 24'h789ABC;
    push_step(9'h007, 24'h123456, -1);
    push_step(9'h03F, 24'h789ABC, 0);
    push_step(9'h1F8, 24'h000000, 0);
    push_step(9'h1C0, 24'h000000, 0);
    push_done(4, 1'b0);
    run_job(2, 72'h0F0F0F0F0F0F0F0F0F, bt, 16'hFFFF, 0, 1'b0, 1'b0);

    repeat (3) tick();
    chk("steps_consumed", 72'(sq.size()), 72'h0);
    chk("dones_consumed", 72'(dq.size()), 72'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
